// File: rtl/tmv_pkg.sv
// Shared types and constants for the TMR channel monitor.
// Tracker state encoding, default persistence threshold and run-counter width.
package tmv_pkg;

  typedef enum logic [1:0] {
    CH_OK      = 2'd0,
    CH_SUSPECT = 2'd1,
    CH_FAILED  = 2'd2
  } ch_state_t;

  localparam int DEFAULT_PERSIST = 4;
  localparam int RUN_W           = 4;

endpackage

// File: rtl/tmv_channel_tracker.sv
// Per-channel miscompare tracker: consecutive-miscompare run, saturating error count,
// and the OK/SUSPECT/FAILED state that drives the channel's voter enable.
module tmv_channel_tracker
  import tmv_pkg::*;
#(
  parameter int PERSIST = DEFAULT_PERSIST,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic             mis,
  input  logic             clear,
  input  logic             grant,
  output logic             reach_persist,
  output logic             failed,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [RUN_W-1:0] PERSIST_RUN = RUN_W'(PERSIST);

  ch_state_t        state, state_next;
  logic [RUN_W-1:0] run, run_next, run_inc;
  logic [CNT_W-1:0] err_next;

  assign run_inc       = run + RUN_W'(1);
  assign reach_persist = sample_valid && mis && (state != CH_FAILED) && (run_inc == PERSIST_RUN);
  assign failed        = (state == CH_FAILED);

  // A tracker that reaches the threshold without the grant falls back to OK so that
  // only one channel is ever dropped from the vote.
  always_comb begin
    state_next = state;
    run_next   = run;
    err_next   = err_cnt;
    if (clear) begin
      state_next = CH_OK;
      run_next   = '0;
    end else if (sample_valid && (state != CH_FAILED)) begin
      if (mis) begin
        if (err_cnt != '1) err_next = err_cnt + CNT_W'(1);
        if (reach_persist) begin
          if (grant) begin
            state_next = CH_FAILED;
            run_next   = run_inc;
          end else begin
            state_next = CH_OK;
            run_next   = '0;
          end
        end else begin
          state_next = CH_SUSPECT;
          run_next   = run_inc;
        end
      end else begin
        state_next = CH_OK;
        run_next   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CH_OK;
      run     <= '0;
      err_cnt <= '0;
    end else begin
      state   <= state_next;
      run     <= run_next;
      err_cnt <= err_next;
    end
  end

endmodule

// File: rtl/tmv_channel_monitor.sv
// Supervisor for a TMR voter: majority check, per-channel failure tracking with
// lowest-index arbitration, and degraded two-channel monitoring once a channel drops.
module tmv_channel_monitor
  import tmv_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int PERSIST = DEFAULT_PERSIST,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic             clear_fail,
  output logic             en1,
  output logic             en2,
  output logic             en3,
  output logic [2:0]       fail,
  output logic [WIDTH-1:0] voted,
  output logic             miscompare,
  output logic             no_majority,
  output logic [CNT_W-1:0] err_cnt1,
  output logic [CNT_W-1:0] err_cnt2,
  output logic [CNT_W-1:0] err_cnt3
);

  logic [WIDTH-1:0] maj, pair_and;
  logic [2:0]       mis, req, grant, failed;
  logic             three_mode, track_valid, pair_differ;

  assign maj         = (a1 & a2) | (a1 & a3) | (a2 & a3);
  assign mis         = {a3 != maj, a2 != maj, a1 != maj};
  assign three_mode  = ~|failed;
  assign track_valid = sample && three_mode;
  assign grant       = {req[2] & ~req[1] & ~req[0], req[1] & ~req[0], req[0]};

  assign en1  = ~failed[0];
  assign en2  = ~failed[1];
  assign en3  = ~failed[2];
  assign fail = failed;

  tmv_channel_tracker #(.PERSIST(PERSIST), .CNT_W(CNT_W)) u_trk1 (
    .clk(clk), .reset(reset), .sample_valid(track_valid), .mis(mis[0]), .clear(clear_fail),
    .grant(grant[0]), .reach_persist(req[0]), .failed(failed[0]), .err_cnt(err_cnt1));
  tmv_channel_tracker #(.PERSIST(PERSIST), .CNT_W(CNT_W)) u_trk2 (
    .clk(clk), .reset(reset), .sample_valid(track_valid), .mis(mis[1]), .clear(clear_fail),
    .grant(grant[1]), .reach_persist(req[1]), .failed(failed[1]), .err_cnt(err_cnt2));
  tmv_channel_tracker #(.PERSIST(PERSIST), .CNT_W(CNT_W)) u_trk3 (
    .clk(clk), .reset(reset), .sample_valid(track_valid), .mis(mis[2]), .clear(clear_fail),
    .grant(grant[2]), .reach_persist(req[2]), .failed(failed[2]), .err_cnt(err_cnt3));

  // With one enable low the voter degenerates to an AND of the remaining pair.
  always_comb begin
    pair_and    = '1;
    pair_differ = 1'b0;
    if (failed[0]) begin
      pair_and    = a2 & a3;
      pair_differ = (a2 != a3);
    end else if (failed[1]) begin
      pair_and    = a1 & a3;
      pair_differ = (a1 != a3);
    end else if (failed[2]) begin
      pair_and    = a1 & a2;
      pair_differ = (a1 != a2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      voted       <= '0;
      miscompare  <= 1'b0;
      no_majority <= 1'b0;
    end else begin
      if (sample) begin
        voted      <= three_mode ? maj : pair_and;
        miscompare <= three_mode ? (|mis) : pair_differ;
      end
      if (clear_fail)
        no_majority <= 1'b0;
      else if (sample && !three_mode && pair_differ)
        no_majority <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tmv_channel_monitor.sv
// Bench for tmv_channel_monitor: directed scenarios against fixed expectations, then
// randomized traffic against a behavioural model of the monitoring rules.
module tb_tmv_channel_monitor;

  localparam int W    = 2;
  localparam int P    = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [W-1:0] ONE  = '1;
  localparam logic [W-1:0] ZERO = '0;

  logic          clk = 1'b0;
  logic          reset, sample, clear_fail;
  logic [W-1:0]  a1, a2, a3;
  logic          en1, en2, en3, miscompare, no_majority;
  logic [2:0]    fail;
  logic [W-1:0]  voted;
  logic [CW-1:0] err_cnt1, err_cnt2, err_cnt3;

  int errors = 0;
  int checks = 0;

  // Model: failed channel index (0 = none), runs, error counts, registered outputs.
  int           m_failed;
  int           m_run [3];
  int           m_err [3];
  bit           m_nomaj, m_mis;
  logic [W-1:0] m_voted;

  tmv_channel_monitor #(.WIDTH(W), .PERSIST(P), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sample(sample), .a1(a1), .a2(a2), .a3(a3),
    .clear_fail(clear_fail), .en1(en1), .en2(en2), .en3(en3), .fail(fail),
    .voted(voted), .miscompare(miscompare), .no_majority(no_majority),
    .err_cnt1(err_cnt1), .err_cnt2(err_cnt2), .err_cnt3(err_cnt3));

  always #5 clk = ~clk;

  task automatic model_update(input bit rst, input bit s, input logic [W-1:0] x1,
                              input logic [W-1:0] x2, input logic [W-1:0] x3, input bit clr);
    logic [W-1:0] ch [3];
    logic [W-1:0] maj;
    logic [W-1:0] live [$];
    int ones, winner;
    ch[0] = x1; ch[1] = x2; ch[2] = x3;
    if (rst) begin
      m_failed = 0; m_nomaj = 0; m_mis = 0; m_voted = '0;
      for (int c = 0; c < 3; c++) begin m_run[c] = 0; m_err[c] = 0; end
      return;
    end
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int c = 0; c < 3; c++) ones += int'(ch[c][b]);
      maj[b] = (ones >= 2);
    end
    if (s) begin
      if (m_failed == 0) begin
        m_voted = maj;
        m_mis   = (x1 != maj) || (x2 != maj) || (x3 != maj);
      end else begin
        for (int c = 0; c < 3; c++) if (c + 1 != m_failed) live.push_back(ch[c]);
        m_voted = live[0] & live[1];
        m_mis   = (live[0] != live[1]);
        if (m_mis) m_nomaj = 1;
      end
    end
    if (clr) begin
      m_failed = 0; m_nomaj = 0;
      for (int c = 0; c < 3; c++) m_run[c] = 0;
    end else if (s && m_failed == 0) begin
      winner = 0;
      for (int c = 0; c < 3; c++) begin
        if (ch[c] != maj) begin
          if (m_err[c] < CMAX) m_err[c]++;
          m_run[c]++;
          if (m_run[c] == P) begin
            if (winner == 0) winner = c + 1;
            else m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_failed = winner;
    end
  endtask

  task automatic drive(input bit rst, input bit s, input logic [W-1:0] x1,
                       input logic [W-1:0] x2, input logic [W-1:0] x3, input bit clr);
    reset = rst; sample = s; a1 = x1; a2 = x2; a3 = x3; clear_fail = clr;
    @(posedge clk);
    model_update(rst, s, x1, x2, x3, clr);
    #1;
  endtask

  task automatic test_reset;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    checks++; if ({en1, en2, en3} !== 3'b111) begin errors++; $display("[TB] FAIL reset_en got=%b exp=111", {en1, en2, en3}); end
    checks++; if (fail !== 3'b000) begin errors++; $display("[TB] FAIL reset_fail got=%b exp=000", fail); end
    checks++; if (voted !== ZERO || miscompare !== 1'b0 || no_majority !== 1'b0) begin errors++;
      $display("[TB] FAIL reset_flags got voted=%b mis=%b nomaj=%b exp 0", voted, miscompare, no_majority); end
    checks++; if ({err_cnt1, err_cnt2, err_cnt3} !== '0) begin errors++;
      $display("[TB] FAIL reset_err got=%0d/%0d/%0d exp=0/0/0", err_cnt1, err_cnt2, err_cnt3); end
  endtask

  task automatic test_agree;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, ONE, ONE, ONE, 0);
    checks++; if ({en1, en2, en3} !== 3'b111 || fail !== 3'b000) begin errors++;
      $display("[TB] FAIL agree_en got en=%b fail=%b exp 111/000", {en1, en2, en3}, fail); end
    checks++; if (voted !== ONE || miscompare !== 1'b0) begin errors++;
      $display("[TB] FAIL agree_vote got voted=%b mis=%b exp %b/0", voted, miscompare, ONE); end
    checks++; if ({err_cnt1, err_cnt2, err_cnt3} !== '0) begin errors++;
      $display("[TB] FAIL agree_err got=%0d/%0d/%0d exp=0/0/0", err_cnt1, err_cnt2, err_cnt3); end
  endtask

  task automatic test_persist;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (fail !== 3'b000 || err_cnt2 !== CW'(3) || miscompare !== 1'b1) begin errors++;
      $display("[TB] FAIL persist_three got fail=%b err2=%0d mis=%b exp 000/3/1", fail, err_cnt2, miscompare); end
    drive(0, 1, ONE, ONE, ONE, 0);
    checks++; if (miscompare !== 1'b0) begin errors++; $display("[TB] FAIL persist_agree got mis=%b exp 0", miscompare); end
    for (int i = 0; i < 3; i++) drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (fail !== 3'b000 || en2 !== 1'b1) begin errors++;
      $display("[TB] FAIL persist_early got fail=%b en2=%b exp 000/1", fail, en2); end
    drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (fail !== 3'b010 || {en1, en2, en3} !== 3'b101) begin errors++;
      $display("[TB] FAIL persist_fail got fail=%b en=%b exp 010/101", fail, {en1, en2, en3}); end
    checks++; if (err_cnt2 !== CW'(7) || err_cnt1 !== '0 || err_cnt3 !== '0) begin errors++;
      $display("[TB] FAIL persist_err got=%0d/%0d/%0d exp=0/7/0", err_cnt1, err_cnt2, err_cnt3); end
  endtask

  task automatic test_simultaneous;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    for (int i = 0; i < P - 1; i++) drive(0, 1, 2'b01, 2'b10, 2'b00, 0);
    checks++; if (fail !== 3'b000) begin errors++; $display("[TB] FAIL simul_early got fail=%b exp 000", fail); end
    drive(0, 1, 2'b01, 2'b10, 2'b00, 0);
    checks++; if (fail !== 3'b001 || {en1, en2, en3} !== 3'b011) begin errors++;
      $display("[TB] FAIL simul_fail got fail=%b en=%b exp 001/011", fail, {en1, en2, en3}); end
    checks++; if (err_cnt1 !== CW'(4) || err_cnt2 !== CW'(4) || err_cnt3 !== '0) begin errors++;
      $display("[TB] FAIL simul_err got=%0d/%0d/%0d exp=4/4/0", err_cnt1, err_cnt2, err_cnt3); end
    drive(0, 0, ZERO, ZERO, ZERO, 1);
    checks++; if (fail !== 3'b000) begin errors++; $display("[TB] FAIL simul_clear got fail=%b exp 000", fail); end
    for (int i = 0; i < P - 1; i++) drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (fail !== 3'b000 || err_cnt2 !== CW'(7)) begin errors++;
      $display("[TB] FAIL simul_run2 got fail=%b err2=%0d exp 000/7", fail, err_cnt2); end
    drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (fail !== 3'b010 || err_cnt2 !== CW'(7)) begin errors++;
      $display("[TB] FAIL simul_sat got fail=%b err2=%0d exp 010/7", fail, err_cnt2); end
  endtask

  task automatic test_two_channel;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    for (int i = 0; i < P; i++) drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (fail !== 3'b010) begin errors++; $display("[TB] FAIL two_setup got fail=%b exp 010", fail); end
    drive(0, 1, ONE, ONE, ZERO, 0);
    checks++; if (no_majority !== 1'b1 || miscompare !== 1'b1 || voted !== ZERO) begin errors++;
      $display("[TB] FAIL two_diff got nomaj=%b mis=%b voted=%b exp 1/1/00", no_majority, miscompare, voted); end
    checks++; if (err_cnt1 !== '0 || err_cnt3 !== '0 || err_cnt2 !== CW'(4)) begin errors++;
      $display("[TB] FAIL two_err got=%0d/%0d/%0d exp=0/4/0", err_cnt1, err_cnt2, err_cnt3); end
    drive(0, 1, ONE, ZERO, ONE, 0);
    checks++; if (no_majority !== 1'b1 || miscompare !== 1'b0 || voted !== ONE) begin errors++;
      $display("[TB] FAIL two_sticky got nomaj=%b mis=%b voted=%b exp 1/0/11", no_majority, miscompare, voted); end
    drive(0, 0, ZERO, ZERO, ZERO, 1);
    checks++; if ({en1, en2, en3} !== 3'b111 || fail !== 3'b000 || no_majority !== 1'b0) begin errors++;
      $display("[TB] FAIL two_clear got en=%b fail=%b nomaj=%b exp 111/000/0", {en1, en2, en3}, fail, no_majority); end
    checks++; if (err_cnt2 !== CW'(4) || voted !== ONE) begin errors++;
      $display("[TB] FAIL two_keep got err2=%0d voted=%b exp 4/11", err_cnt2, voted); end
  endtask

  task automatic test_saturate_clear;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    drive(0, 1, ONE, ZERO, ONE, 1);
    checks++; if (err_cnt2 !== '0 || voted !== ONE || miscompare !== 1'b1) begin errors++;
      $display("[TB] FAIL clrsamp_err got err2=%0d voted=%b mis=%b exp 0/11/1", err_cnt2, voted, miscompare); end
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, ONE, ONE, ZERO, 0);
      drive(0, 1, ONE, ONE, ONE, 0);
    end
    checks++; if (err_cnt3 !== CW'(CMAX) || fail !== 3'b000) begin errors++;
      $display("[TB] FAIL sat_err got err3=%0d fail=%b exp %0d/000", err_cnt3, fail, CMAX); end
    for (int i = 0; i < P - 1; i++) drive(0, 1, ONE, ONE, ZERO, 0);
    drive(0, 1, ONE, ONE, ZERO, 1);
    for (int i = 0; i < P - 1; i++) drive(0, 1, ONE, ONE, ZERO, 0);
    checks++; if (fail !== 3'b000) begin errors++; $display("[TB] FAIL clrsamp_run got fail=%b exp 000", fail); end
    drive(0, 1, ONE, ONE, ZERO, 0);
    checks++; if (fail !== 3'b100 || {en1, en2, en3} !== 3'b110 || err_cnt3 !== CW'(CMAX)) begin errors++;
      $display("[TB] FAIL clrsamp_fail got fail=%b en=%b err3=%0d exp 100/110/%0d", fail, {en1, en2, en3}, err_cnt3, CMAX); end
  endtask

  task automatic test_mid_reset;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    for (int i = 0; i < 2; i++) drive(0, 1, ZERO, ONE, ONE, 0);
    drive(1, 1, ZERO, ONE, ONE, 1);
    checks++; if ({en1, en2, en3} !== 3'b111 || fail !== 3'b000 || voted !== ZERO || miscompare !== 1'b0
                  || no_majority !== 1'b0 || err_cnt1 !== '0) begin errors++;
      $display("[TB] FAIL midrst got en=%b fail=%b voted=%b mis=%b nomaj=%b err1=%0d exp reset values",
               {en1, en2, en3}, fail, voted, miscompare, no_majority, err_cnt1); end
    for (int i = 0; i < P - 1; i++) drive(0, 1, ZERO, ONE, ONE, 0);
    checks++; if (fail !== 3'b000) begin errors++; $display("[TB] FAIL midrst_run got fail=%b exp 000", fail); end
    drive(0, 1, ZERO, ONE, ONE, 0);
    checks++; if (fail !== 3'b001) begin errors++; $display("[TB] FAIL midrst_fail got fail=%b exp 001", fail); end
  endtask

  task automatic test_random;
    logic [W-1:0] ch [3];
    logic [W-1:0] base;
    logic [2:0]   exp_en, exp_fail;
    int bad;
    bit s, clr, rst;
    drive(1, 0, ZERO, ZERO, ZERO, 0);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) bad = $urandom_range(0, 3);
      base = W'($urandom);
      for (int c = 0; c < 3; c++) begin
        ch[c] = base;
        if (c + 1 == bad) begin
          if ($urandom_range(0, 3) != 0) ch[c] = base ^ W'($urandom_range(1, 3));
        end else if ($urandom_range(0, 9) == 0) begin
          ch[c] = base ^ W'($urandom_range(1, 3));
        end
      end
      s   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 149) == 0);
      drive(rst, s, ch[0], ch[1], ch[2], clr);
      exp_en = 3'b111; exp_fail = 3'b000;
      if (m_failed != 0) begin exp_en[3 - m_failed] = 1'b0; exp_fail[m_failed - 1] = 1'b1; end
      checks++; if ({en1, en2, en3} !== exp_en) begin errors++; $display("[TB] FAIL rnd_en cyc=%0d got=%b exp=%b", i, {en1, en2, en3}, exp_en); end
      checks++; if (fail !== exp_fail) begin errors++; $display("[TB] FAIL rnd_fail cyc=%0d got=%b exp=%b", i, fail, exp_fail); end
      checks++; if (voted !== m_voted) begin errors++; $display("[TB] FAIL rnd_voted cyc=%0d got=%b exp=%b", i, voted, m_voted); end
      checks++; if (miscompare !== m_mis) begin errors++; $display("[TB] FAIL rnd_mis cyc=%0d got=%b exp=%b", i, miscompare, m_mis); end
      checks++; if (no_majority !== m_nomaj) begin errors++; $display("[TB] FAIL rnd_nomaj cyc=%0d got=%b exp=%b", i, no_majority, m_nomaj); end
      checks++; if (err_cnt1 !== CW'(m_err[0])) begin errors++; $display("[TB] FAIL rnd_err1 cyc=%0d got=%0d exp=%0d", i, err_cnt1, m_err[0]); end
      checks++; if (err_cnt2 !== CW'(m_err[1])) begin errors++; $display("[TB] FAIL rnd_err2 cyc=%0d got=%0d exp=%0d", i, err_cnt2, m_err[1]); end
      checks++; if (err_cnt3 !== CW'(m_err[2])) begin errors++; $display("[TB] FAIL rnd_err3 cyc=%0d got=%0d exp=%0d", i, err_cnt3, m_err[2]); end
    end
  endtask

  initial begin
    reset = 1'b1; sample = 1'b0; clear_fail = 1'b0;
    a1 = ZERO; a2 = ZERO; a3 = ZERO;
    test_reset();
    test_agree();
    test_persist();
    test_simultaneous();
    test_two_channel();
    test_saturate_clear();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmv_channel_monitor.md
Name: tmv_channel_monitor

Overview:
- Supervisory companion to the triple-modular-redundancy majority voter. The voter consumes three replicated channels plus per-channel enables; this block produces those enables.
- Samples the three channel values, forms a bitwise majority, and tracks per-channel miscompares.
- A channel that miscompares for PERSIST consecutive samples is declared failed and its enable is dropped. It stays failed until software clears it.
- Also supplies saturating per-channel error counts and a sticky no-majority flag for telemetry.

Parameters:
- WIDTH, 1, bits per channel word.
- PERSIST, 4, consecutive miscompare samples needed to declare a channel failed (range 1..15).
- CNT_W, 8, width of each saturating error-event counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- sample  input  1  qualifies a1..a3 this cycle; non-sample cycles are ignored.
- a1  input  WIDTH  channel 1 value.
- a2  input  WIDTH  channel 2 value.
- a3  input  WIDTH  channel 3 value.
- clear_fail  input  1  pulse; re-enables all channels and clears run counters and no_majority.
- en1  output  1  enable to voter, channel 1.
- en2  output  1  enable to voter, channel 2.
- en3  output  1  enable to voter, channel 3.
- fail  output  3  bit i-1 high = channel i failed.
- voted  output  WIDTH  registered majority of the last sample.
- miscompare  output  1  registered; last sample had any enabled channel disagreeing.
- no_majority  output  1  sticky; disagreement seen with only two channels enabled.
- err_cnt1  output  CNT_W  saturating miscompare count, channel 1.
- err_cnt2  output  CNT_W  saturating miscompare count, channel 2.
- err_cnt3  output  CNT_W  saturating miscompare count, channel 3.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: en1..en3=1, fail=0, voted=0, miscompare=0, no_majority=0, err_cnt*=0, run counters=0, all trackers in CH_OK.
- Majority: bitwise (a1&a2)|(a1&a3)|(a2&a3), true polarity (not inverted like the voter output).
- voted and miscompare update one cycle after a sample cycle and hold otherwise.

Per-channel tracker, mode with three channels enabled (channel i is an enabled channel):
- Miscompare when a_i != majority, any bit.
- On a sampled miscompare, increment run_i and the saturating err_cnt_i.
- On a sampled agreement, run_i returns to 0.

Tracker states:
- CH_OK: run_i=0. A miscompare moves to CH_SUSPECT (run_i=1), or straight to CH_FAILED if PERSIST=1.
- CH_SUSPECT: a miscompare with run_i+1==PERSIST moves to CH_FAILED; an agreement returns to CH_OK.
- CH_FAILED: en_i=0, fail[i-1]=1. run_i frozen; err_cnt_i frozen.
- en_i and fail change on the cycle after the sample that reaches PERSIST.

Boundaries and special cases:
- At most one channel may be FAILED at a time.
  - If two or three trackers would reach PERSIST on the same sample, only the lowest-index channel fails.
  - The others return to CH_OK with run=0; their err_cnt still increments for that sample.
- Two-channel mode (one FAILED): no attribution.
  - Any bit difference between the two enabled channels sets no_majority (sticky) and miscompare.
  - No run or err_cnt changes.
  - voted = AND of the two enabled channels, matching voter behaviour with one enable low.
- err_cnt saturates at 2^CNT_W-1, with no wrap.
- clear_fail:
  - Takes effect next cycle: all trackers to CH_OK, run=0, en=1, fail=0, no_majority=0.
  - err_cnt, voted and miscompare are not cleared.
  - clear_fail coincident with a sample: clear wins and that sample is discarded for run/err purposes (voted still updates).
- reset asserted mid-run overrides everything, including clear_fail and sample.
- sample low: all state holds.

Decomposition:
- Package tmv_pkg holds:
  - the tracker state encoding CH_OK=2'd0, CH_SUSPECT=2'd1, CH_FAILED=2'd2;
  - the default PERSIST constant;
  - a run-counter width constant of 4 bits.
- One sub-module, tmv_channel_tracker, instantiated three times.
  - Contains the state, run counter and err_cnt.
  - Inputs: sample_valid, mis, clear, grant.
  - Outputs: reach_persist request, failed.
- The top level holds the majority logic, the lowest-index grant arbitration, the two-channel mode, and the output registers.

Test Plan:
- Reset then 10 samples with a1=a2=a3=1 (WIDTH=1) -> en=111, fail=000, voted=1, miscompare=0, all err_cnt=0.
- a2 inverted for 3 samples, then agreement, then 4 inverted -> no failure after 3 (err_cnt2=3, run reset); fail[1]=1 and en2=0 exactly one cycle after the 4th of the following 4 samples; err_cnt2=7.
- WIDTH=2, a1=01, a2=10, a3=00 for PERSIST samples -> channel 1 fails only; channel 2 stays enabled with run=0; err_cnt1=err_cnt2=4.
- With channel 2 failed, sample a1=1, a3=0 -> no_majority=1, miscompare=1, voted=0, err_cnt1/3 unchanged; then clear_fail -> en=111, fail=000, no_majority=0 next cycle.
- CNT_W=2, channel 3 miscompares on 5 non-consecutive samples -> err_cnt3 sticks at 3; clear_fail with sample in the same cycle -> run cleared and that sample not counted.
- reset asserted while channel 1 is in CH_SUSPECT with run=2 -> next cycle all outputs at reset values and run=0.
